// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction-memory responder.
package imem_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] instr;
    logic        err;
  } rsp_entry_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/imem_rsp_fifo.sv
// In-order response queue; pointers carry an extra wrap bit, clear empties it in one cycle.
module imem_rsp_fifo
  import imem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       wr_en,
  input  rsp_entry_t wr_data,
  input  logic       rd_en,
  output rsp_entry_t rd_data,
  output logic       empty
);

  localparam int PW = clog2(DEPTH);

  rsp_entry_t      store [DEPTH];
  logic [PW:0]     wptr, rptr;
  logic            full;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
  assign rd_data = store[rptr[PW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else if (clear) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en && !full) wptr <= wptr + 1'b1;
      if (rd_en && !empty) rptr <= rptr + 1'b1;
    end
  end

  // Entries are only visible once the pointers say so, so storage needs no reset.
  always_ff @(posedge clk) begin
    if (wr_en && !full && !clear) store[wptr[PW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: fixed-latency fetch returns, credit-limited queue, flush.
// Optional build macro IMEM_ALIGN_CHECK_EN flags misaligned fetches as access faults.
module imem_responder
  import imem_pkg::*;
#(
  parameter int  DEPTH      = 1024,
  parameter int  LAT        = 2,
  parameter int  FIFO_DEPTH = 4,
  localparam int AW         = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [31:0]   req_addr,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_instr,
  output logic [31:0]   rsp_addr,
  output logic          rsp_err,
  input  logic          flush,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [31:0]   prog_data
);

  localparam int          CW    = clog2(FIFO_DEPTH) + 1;
  localparam logic [32:0] LIMIT = 33'(DEPTH) * 33'd4;

  logic [31:0]   mem [DEPTH];
  logic [CW-1:0] count;
  logic          accept, pop, acc_err;
  logic          fifo_we, fifo_empty;
  rsp_entry_t    acc_entry, fifo_wd, fifo_rd;

  // count is registered, so req_ready never depends on rsp_ready combinationally.
  assign req_ready = (count < CW'(FIFO_DEPTH)) && !flush;
  assign accept    = req_valid && req_ready;
  assign pop       = rsp_valid && rsp_ready;

  always_comb begin
    acc_err = ({1'b0, req_addr} >= LIMIT);
`ifdef IMEM_ALIGN_CHECK_EN
    if (req_addr[1:0] != 2'b00) acc_err = 1'b1;
`endif
    acc_entry.addr  = req_addr;
    acc_entry.err   = acc_err;
    acc_entry.instr = acc_err ? NOP_INSTR : mem[req_addr[AW+1:2]];
  end

  // Read happens before this edge, so a same-cycle fetch of the written word sees old data.
  always_ff @(posedge clk) begin
    if (prog_we) mem[prog_addr] <= prog_data;
  end

  generate
    if (LAT == 1) begin : g_nopipe
      assign fifo_we = accept;
      assign fifo_wd = acc_entry;
    end else begin : g_pipe
      logic [LAT-1:1] vld_pipe;
      rsp_entry_t     data_pipe [LAT-1:1];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          vld_pipe <= '0;
        end else if (flush) begin
          vld_pipe <= '0;
        end else begin
          vld_pipe[1] <= accept;
          for (int i = 2; i < LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
      end

      always_ff @(posedge clk) begin
        data_pipe[1] <= acc_entry;
        for (int i = 2; i < LAT; i++) data_pipe[i] <= data_pipe[i-1];
      end

      assign fifo_we = vld_pipe[LAT-1];
      assign fifo_wd = data_pipe[LAT-1];
    end
  endgenerate

  imem_rsp_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .clear   (flush),
    .wr_en   (fifo_we),
    .wr_data (fifo_wd),
    .rd_en   (pop),
    .rd_data (fifo_rd),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload is forced to zero while idle so the outputs read clean after reset.
  assign rsp_valid = !fifo_empty;
  assign rsp_instr = rsp_valid ? fifo_rd.instr : 32'h0;
  assign rsp_addr  = rsp_valid ? fifo_rd.addr  : 32'h0;
  assign rsp_err   = rsp_valid ? fifo_rd.err   : 1'b0;

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: accepts push expected entries, a monitor pops and compares.
module tb_imem_responder;
  import imem_pkg::*;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic        err;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_instr, rsp_addr;
  logic        rsp_err;
  logic        flush;
  logic        prog_we;
  logic [9:0]  prog_addr;
  logic [31:0] prog_data;

  logic [31:0] tb_mem [DEPTH];
  exp_t        q[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          exp_rdy = -1;
  int          exp_rv = -1;
  bit          lat_chk = 0;
  bit          final_chk = 0;

  imem_responder #(.DEPTH(DEPTH), .LAT(LAT), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr),
    .rsp_addr(rsp_addr), .rsp_err(rsp_err), .flush(flush),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [31:0] a, input bit chk);
    exp_t e;
    logic [31:0] tmp;
    e.addr = a;
    e.err  = (a >= 32'(DEPTH * 4));
`ifdef IMEM_ALIGN_CHECK_EN
    if (a[1:0] != 2'b00) e.err = 1'b1;
`endif
    tmp     = tb_mem[a[11:2]];
    e.instr = e.err ? 32'h0000_0013 : tmp;
    e.cyc   = chk ? cyc + LAT : -1;
    return e;
  endfunction

  // Monitor: all comparisons happen here, on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      tests++;
      if ({rsp_valid, rsp_instr, rsp_addr, rsp_err} !== 66'h0) begin
        fails++;
        $display("FAIL reset_outputs: got v=%b i=%h a=%h e=%b, want all zero",
                 rsp_valid, rsp_instr, rsp_addr, rsp_err);
      end
      q.delete();
    end else begin
      if (exp_rdy >= 0) begin
        tests++;
        if (req_ready !== exp_rdy[0]) begin
          fails++;
          $display("FAIL req_ready @%0d: got %b, want %0d", cyc, req_ready, exp_rdy);
        end
      end
      if (exp_rv >= 0) begin
        tests++;
        if (rsp_valid !== exp_rv[0]) begin
          fails++;
          $display("FAIL rsp_valid @%0d: got %b, want %0d", cyc, rsp_valid, exp_rv);
        end
      end
      if (rsp_valid) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL stale_rsp @%0d: got addr=%h instr=%h, want no response", cyc, rsp_addr, rsp_instr);
        end else begin
          if ({rsp_addr, rsp_instr, rsp_err} !== {q[0].addr, q[0].instr, q[0].err}) begin
            fails++;
            $display("FAIL rsp_data @%0d: got a=%h i=%h e=%b, want a=%h i=%h e=%b", cyc,
                     rsp_addr, rsp_instr, rsp_err, q[0].addr, q[0].instr, q[0].err);
          end
          if (rsp_ready) begin
            if (q[0].cyc >= 0) begin
              tests++;
              if (cyc != q[0].cyc) begin
                fails++;
                $display("FAIL latency addr=%h: got cycle %0d, want %0d", q[0].addr, cyc, q[0].cyc);
              end
            end
            void'(q.pop_front());
          end
        end
      end
      if (flush) q.delete();
      else if (req_valid && req_ready) q.push_back(model(req_addr, lat_chk));
      if (prog_we) tb_mem[prog_addr] = prog_data;
      if (final_chk) begin
        tests++;
        if (q.size() != 0) begin
          fails++;
          $display("FAIL drain: got %0d responses missing, want 0", q.size());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    exp_rdy = -1;
    exp_rv  = -1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
    flush = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    exp_rdy = 1;

    // Program words 0..17 and the last word
    for (int i = 0; i < 18; i++) begin
      tick(); prog_we = 1'b1; prog_addr = 10'(i); prog_data = 32'hA000_0000 + 32'(i) * 32'h111;
    end
    tick(); prog_addr = 10'd1023; prog_data = 32'h5555_AAAA;
    tick(); prog_we = 1'b0;

    // Back-to-back, fixed latency
    lat_chk = 1;
    for (int i = 0; i < 4; i++) begin
      tick(); req_valid = 1'b1; req_addr = 32'(i * 4); exp_rdy = 1;
    end
    tick(); req_valid = 1'b0; exp_rdy = 1; lat_chk = 0;
    repeat (5) tick();

    // Backpressure: only 4 credits
    for (int i = 0; i < 6; i++) begin
      tick(); rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h10 + 32'(i * 4); exp_rdy = (i < 4) ? 1 : 0;
    end
    tick(); req_valid = 1'b0; exp_rdy = 0; exp_rv = 1;
    tick(); exp_rdy = 0; exp_rv = 1;
    tick(); rsp_ready = 1'b1; exp_rdy = 0;
    tick(); exp_rdy = 1;
    repeat (5) tick();

    // Flush with 3 outstanding
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); req_valid = 1'b1; req_addr = 32'(i * 4); exp_rdy = 1;
    end
    tick(); req_valid = 1'b0; flush = 1'b1; exp_rdy = 0;
    tick(); flush = 1'b0; exp_rv = 0; exp_rdy = 1;
    rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h40; lat_chk = 1;
    tick(); req_valid = 1'b0; lat_chk = 0;
    repeat (4) tick();

    // Range, alignment, last word, same-cycle program/fetch
    tick(); req_valid = 1'b1; req_addr = 32'h0000_1000;
    tick(); req_addr = 32'hFFFF_FFFC;
    tick(); req_addr = 32'h0000_0006;
    tick(); req_addr = 32'h0000_0FFC;
    tick(); req_addr = 32'h0000_0014; prog_we = 1'b1; prog_addr = 10'd5; prog_data = 32'hDEAD_BEEF;
    tick(); req_addr = 32'h0000_0014; prog_we = 1'b0;
    tick(); req_valid = 1'b0;
    repeat (5) tick();

    // Asynchronous reset with 2 outstanding
    rsp_ready = 1'b0;
    tick(); req_valid = 1'b1; req_addr = 32'h0;
    tick(); req_addr = 32'h4;
    tick(); req_valid = 1'b0;
    tick(); exp_rv = 1;
    tick();
    #2 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    exp_rdy = 1; exp_rv = 0; rsp_ready = 1'b1;
    repeat (6) tick();

    final_chk = 1;
    tick();
    final_chk = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
